// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: pipelined branch resolution with misprediction flush and squash window. Rev 1.0
// Optional macro BRU_PERF_CNT_EN adds saturating branch/mispredict counters.
`default_nettype none

module branch_resolve_unit #(
  parameter int XLEN          = 32,
  parameter int PIPE_STAGES   = 1,
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_WIDTH     = 32
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            branch,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  input  logic            kill,
`ifdef BRU_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0] br_count,
  output logic [CNT_WIDTH-1:0] mispred_count,
`endif
  output logic            illegal
);

  localparam int              SQ_W    = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;
  localparam logic [SQ_W-1:0] SQ_LAST = SQ_W'(SQUASH_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [SQ_W-1:0] sq_cnt_q, sq_cnt_d;

  logic            out_valid_q, taken_q, mispredict_q, illegal_q, branch_q;
  logic [XLEN-1:0] target_q, redirect_q;

  logic w_advance, w_fire_out, w_accept;

  assign w_advance  = !out_valid_q || out_ready;
  assign w_fire_out = out_valid_q && out_ready;
  // kill outranks a coinciding mispredict: no redirect is raised for it
  assign flush      = w_fire_out && mispredict_q && (state_q == ST_RUN) && !kill;
  assign w_accept   = in_valid && w_advance && (state_q == ST_RUN) && !flush && !kill;
  assign in_ready   = w_advance;

  // Condition resolution
  logic            w_eq, w_lt_s, w_lt_u, w_cond, w_bad_f3;
  logic            w_res_taken, w_res_illegal;
  logic [XLEN-1:0] w_res_target, w_res_pc4;

  assign w_eq   = (rs1 == rs2);
  assign w_lt_s = ($signed(rs1) < $signed(rs2));
  assign w_lt_u = (rs1 < rs2);

  always_comb begin
    w_cond   = 1'b0;
    w_bad_f3 = 1'b0;
    case (func3)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = !w_eq;
      3'b100:  w_cond = w_lt_s;
      3'b101:  w_cond = !w_lt_s;
      3'b110:  w_cond = w_lt_u;
      3'b111:  w_cond = !w_lt_u;
      default: w_bad_f3 = 1'b1;
    endcase
  end

  assign w_res_taken   = branch && w_cond;
  assign w_res_illegal = branch && w_bad_f3;
  assign w_res_target  = pc + imm;
  assign w_res_pc4     = pc + XLEN'(4);

  // Operands feeding the output register, from either the input or stage 1
  logic            w_o_valid, w_o_taken, w_o_illegal, w_o_branch, w_o_pred_taken;
  logic [XLEN-1:0] w_o_target, w_o_pc4, w_o_pred_target;
  logic            w_o_mispredict;
  logic [XLEN-1:0] w_o_redirect;

  generate
    if (PIPE_STAGES == 2) begin : g_two_stage
      logic            s1_valid_q, s1_taken_q, s1_illegal_q, s1_branch_q, s1_pred_taken_q;
      logic [XLEN-1:0] s1_target_q, s1_pc4_q, s1_pred_target_q;

      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          s1_valid_q       <= 1'b0;
          s1_taken_q       <= 1'b0;
          s1_illegal_q     <= 1'b0;
          s1_branch_q      <= 1'b0;
          s1_pred_taken_q  <= 1'b0;
          s1_target_q      <= '0;
          s1_pc4_q         <= '0;
          s1_pred_target_q <= '0;
        end else if (kill || flush) begin
          s1_valid_q <= 1'b0;
        end else if (w_advance) begin
          s1_valid_q <= w_accept;
          if (w_accept) begin
            s1_taken_q       <= w_res_taken;
            s1_illegal_q     <= w_res_illegal;
            s1_branch_q      <= branch;
            s1_pred_taken_q  <= pred_taken;
            s1_target_q      <= w_res_target;
            s1_pc4_q         <= w_res_pc4;
            s1_pred_target_q <= pred_target;
          end
        end
      end

      // the stage-1 op is younger than a flushing op and must not advance
      assign w_o_valid       = s1_valid_q && !flush;
      assign w_o_taken       = s1_taken_q;
      assign w_o_illegal     = s1_illegal_q;
      assign w_o_branch      = s1_branch_q;
      assign w_o_pred_taken  = s1_pred_taken_q;
      assign w_o_target      = s1_target_q;
      assign w_o_pc4         = s1_pc4_q;
      assign w_o_pred_target = s1_pred_target_q;
    end else begin : g_one_stage
      assign w_o_valid       = w_accept;
      assign w_o_taken       = w_res_taken;
      assign w_o_illegal     = w_res_illegal;
      assign w_o_branch      = branch;
      assign w_o_pred_taken  = pred_taken;
      assign w_o_target      = w_res_target;
      assign w_o_pc4         = w_res_pc4;
      assign w_o_pred_target = pred_target;
    end
  endgenerate

  assign w_o_mispredict = (w_o_taken != w_o_pred_taken) ||
                          (w_o_taken && (w_o_pred_target != w_o_target));
  assign w_o_redirect   = w_o_taken ? w_o_target : w_o_pc4;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      branch_q     <= 1'b0;
      target_q     <= '0;
      redirect_q   <= '0;
    end else if (kill) begin
      out_valid_q <= 1'b0;
    end else if (w_advance) begin
      out_valid_q <= w_o_valid;
      if (w_o_valid) begin
        taken_q      <= w_o_taken;
        mispredict_q <= w_o_mispredict;
        illegal_q    <= w_o_illegal;
        branch_q     <= w_o_branch;
        target_q     <= w_o_target;
        redirect_q   <= w_o_redirect;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign taken       = taken_q;
  assign mispredict  = mispredict_q;
  assign illegal     = illegal_q;
  assign target      = target_q;
  assign redirect_pc = redirect_q;

  // Squash FSM
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= ST_RUN;
      sq_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sq_cnt_q <= sq_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    if (kill) begin
      state_d  = ST_RUN;
      sq_cnt_d = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (flush) begin
            state_d  = ST_SQUASH;
            sq_cnt_d = '0;
          end
        end
        ST_SQUASH: begin
          if (sq_cnt_q == SQ_LAST) begin
            state_d  = ST_RUN;
            sq_cnt_d = '0;
          end else begin
            sq_cnt_d = sq_cnt_q + SQ_W'(1);
          end
        end
        default: begin
          state_d  = ST_RUN;
          sq_cnt_d = '0;
        end
      endcase
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] br_cnt_q, mispred_cnt_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (w_fire_out && branch_q && (br_cnt_q != '1)) begin
        br_cnt_q <= br_cnt_q + CNT_WIDTH'(1);
      end
      if (w_fire_out && mispredict_q && (mispred_cnt_q != '1)) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign br_count      = br_cnt_q;
  assign mispred_count = mispred_cnt_q;
`else
  logic w_unused_perf;
  assign w_unused_perf = branch_q & (CNT_WIDTH != 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed checks of branch_resolve_unit (2-stage main instance, 1-stage latency instance).
`default_nettype none

module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        in_valid, branch, pred_taken, kill, out_ready;
  logic [2:0]  func3;
  logic [31:0] rs1, rs2, pc, imm, pred_target;
  logic        in_ready, out_valid, taken, mispredict, flush, illegal;
  logic [31:0] target, redirect_pc;
  logic        out_ready1 = 1'b1;
  logic        in_ready1, out_valid1, taken1, mispredict1, flush1, illegal1;
  logic [31:0] target1, redirect_pc1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .PIPE_STAGES(2), .SQUASH_CYCLES(2), .CNT_WIDTH(32)) dut (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready), .branch(branch),
    .func3(func3), .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm), .pred_taken(pred_taken),
    .pred_target(pred_target), .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .target(target), .mispredict(mispredict), .redirect_pc(redirect_pc), .flush(flush),
    .kill(kill), .illegal(illegal)
  );

  branch_resolve_unit #(.XLEN(32), .PIPE_STAGES(1), .SQUASH_CYCLES(2), .CNT_WIDTH(32)) dut1 (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready1), .branch(branch),
    .func3(func3), .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm), .pred_taken(pred_taken),
    .pred_target(pred_target), .out_valid(out_valid1), .out_ready(out_ready1), .taken(taken1),
    .target(target1), .mispredict(mispredict1), .redirect_pc(redirect_pc1), .flush(flush1),
    .kill(kill), .illegal(illegal1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] i, input logic pt, input logic [31:0] ptg);
    in_valid    = 1'b1;
    branch      = br;
    func3       = f;
    rs1         = a;
    rs2         = b;
    pc          = p;
    imm         = i;
    pred_taken  = pt;
    pred_target = ptg;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({out_valid, taken, mispredict, illegal, flush} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {out_valid, taken, mispredict, illegal, flush});
    end
    checks++;
    if ({target, redirect_pc} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h expected 0/0", target, redirect_pc);
    end
    #4 rstN = 1'b1;
    tick();
  endtask

  task automatic test_pipe1();
    drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h10, 1'b1, 32'h210);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid1, taken1, mispredict1, redirect_pc1} !== {3'b110, 32'h210}) begin
      errors++;
      $display("FAIL pipe1_latency: got v=%b t=%b m=%b r=%h expected v=1 t=1 m=0 r=210",
               out_valid1, taken1, mispredict1, redirect_pc1);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pipe2_not_early: got out_valid=%b expected 0", out_valid);
    end
    tick();
    checks++;
    if ({out_valid, taken, out_valid1} !== 3'b110) begin
      errors++;
      $display("FAIL pipe2_latency: got v2=%b t2=%b v1=%b expected 1 1 0", out_valid, taken, out_valid1);
    end
  endtask

  task automatic test_compare();
    logic [2:0]  f   [6] = '{3'b100, 3'b110, 3'b111, 3'b010, 3'b101, 3'b001};
    logic [31:0] a   [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3, 32'hFFFF_FFFF, 32'h1};
    logic [31:0] b   [6] = '{32'h1, 32'h1, 32'h1, 32'h3, 32'h1, 32'h2};
    logic [31:0] im  [6] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'hFFFF_FFF0};
    logic        pt  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] ptg [6] = '{32'h210, 32'h0, 32'h210, 32'h0, 32'h0, 32'h1F0};
    logic        et  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        ei  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] etg [6] = '{32'h210, 32'h210, 32'h210, 32'h210, 32'h210, 32'h1F0};
    logic [31:0] erd [6] = '{32'h210, 32'h204, 32'h210, 32'h204, 32'h204, 32'h1F0};
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) drive(1'b1, f[k], a[k], b[k], 32'h200, im[k], pt[k], ptg[k]);
      else in_valid = 1'b0;
      tick();
      if (k >= 1) begin
        checks++;
        if ({out_valid, taken, illegal, mispredict, target, redirect_pc} !==
            {1'b1, et[k-1], ei[k-1], 1'b0, etg[k-1], erd[k-1]}) begin
          errors++;
          $display("FAIL compare[%0d]: got v=%b t=%b i=%b m=%b tg=%h rd=%h expected v=1 t=%b i=%b m=0 tg=%h rd=%h",
                   k-1, out_valid, taken, illegal, mispredict, target, redirect_pc,
                   et[k-1], ei[k-1], etg[k-1], erd[k-1]);
        end
      end
    end
  endtask

  task automatic test_mispredict_flush();
    drive(1'b1, 3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b0, 32'h0);
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, taken, mispredict, flush, target, redirect_pc} !== {4'b1111, 32'h120, 32'h120}) begin
      errors++;
      $display("FAIL flush_event: got v=%b t=%b m=%b f=%b tg=%h rd=%h expected 1 1 1 1 120 120",
               out_valid, taken, mispredict, flush, target, redirect_pc);
    end
    tick();
    checks++;
    if ({out_valid, flush} !== 2'b00) begin
      errors++;
      $display("FAIL flush_pulse: got v=%b f=%b expected 0 0", out_valid, flush);
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'hA00, 32'h0, 1'b0, 32'h0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL squash_drop_a: got out_valid=%b expected 0", out_valid);
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'hB00, 32'h0, 1'b0, 32'h0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL squash_drop_b: got out_valid=%b expected 0", out_valid);
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h300, 32'h0, 1'b0, 32'h0);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL squash_drop_c: got out_valid=%b expected 0", out_valid);
    end
    tick();
    checks++;
    if ({out_valid, mispredict, redirect_pc} !== {2'b10, 32'h304}) begin
      errors++;
      $display("FAIL after_squash: got v=%b m=%b rd=%h expected 1 0 304", out_valid, mispredict, redirect_pc);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 3'b001, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h8, 1'b1, 32'h4);
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, taken, mispredict, flush, target, redirect_pc} !== {4'b1011, 32'h4, 32'h0}) begin
      errors++;
      $display("FAIL wrap: got v=%b t=%b m=%b f=%b tg=%h rd=%h expected 1 0 1 1 4 0",
               out_valid, taken, mispredict, flush, target, redirect_pc);
    end
    repeat (4) tick();
  endtask

  task automatic test_backpressure();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h400, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h410, 32'h0, 1'b0, 32'h0);
    tick();
    out_ready = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h420, 32'h0, 1'b0, 32'h0);
    #1;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if ({out_valid, in_ready, redirect_pc} !== {2'b10, 32'h404}) begin
        errors++;
        $display("FAIL stall[%0d]: got v=%b rdy=%b rd=%h expected 1 0 404", s, out_valid, in_ready, redirect_pc);
      end
      if (s < 3) tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, redirect_pc} !== {1'b1, 32'h414}) begin
      errors++;
      $display("FAIL bp_op1: got v=%b rd=%h expected 1 414", out_valid, redirect_pc);
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h430, 32'h0, 1'b0, 32'h0);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, redirect_pc} !== {1'b1, 32'h424}) begin
      errors++;
      $display("FAIL bp_op2: got v=%b rd=%h expected 1 424", out_valid, redirect_pc);
    end
    tick();
    checks++;
    if ({out_valid, redirect_pc} !== {1'b1, 32'h434}) begin
      errors++;
      $display("FAIL bp_op3: got v=%b rd=%h expected 1 434", out_valid, redirect_pc);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_kill();
    drive(1'b1, 3'b000, 32'h1, 32'h1, 32'h600, 32'h8, 1'b1, 32'h700);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h610, 32'h0, 1'b0, 32'h0);
    tick();
    checks++;
    if ({out_valid, taken, mispredict, target} !== {3'b111, 32'h608}) begin
      errors++;
      $display("FAIL target_mismatch: got v=%b t=%b m=%b tg=%h expected 1 1 1 608",
               out_valid, taken, mispredict, target);
    end
    kill = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h900, 32'h0, 1'b0, 32'h0);
    #1;
    checks++;
    if (flush !== 1'b0) begin
      errors++;
      $display("FAIL kill_no_flush: got flush=%b expected 0", flush);
    end
    tick();
    kill = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL kill_empty: got out_valid=%b expected 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL kill_dropped: got out_valid=%b expected 0", out_valid);
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h800, 32'h0, 1'b0, 32'h0);
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, mispredict, flush, redirect_pc} !== {3'b100, 32'h804}) begin
      errors++;
      $display("FAIL after_kill: got v=%b m=%b f=%b rd=%h expected 1 0 0 804",
               out_valid, mispredict, flush, redirect_pc);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 3'b000, 32'h5, 32'h5, 32'h500, 32'h40, 1'b0, 32'h0);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    checks++;
    if ({out_valid, taken, mispredict, flush, target} !== {4'b1110, 32'h540}) begin
      errors++;
      $display("FAIL held_pre_reset: got v=%b t=%b m=%b f=%b tg=%h expected 1 1 1 0 540",
               out_valid, taken, mispredict, flush, target);
    end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if ({out_valid, taken, mispredict, flush, target, redirect_pc} !== 68'h0) begin
      errors++;
      $display("FAIL async_reset_held: got v=%b t=%b m=%b f=%b tg=%h rd=%h expected all 0",
               out_valid, taken, mispredict, flush, target, redirect_pc);
    end
    out_ready = 1'b1;
    #1 rstN = 1'b1;
    tick();
    drive(1'b1, 3'b000, 32'h5, 32'h5, 32'h500, 32'h40, 1'b0, 32'h0);
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (flush !== 1'b1) begin
      errors++;
      $display("FAIL reset_setup_flush: got flush=%b expected 1", flush);
    end
    tick();
    #2 rstN = 1'b0;
    #1;
    checks++;
    if ({out_valid, flush} !== 2'b00) begin
      errors++;
      $display("FAIL async_reset_squash: got v=%b f=%b expected 0 0", out_valid, flush);
    end
    #1 rstN = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'hC00, 32'h0, 1'b0, 32'h0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: got in_ready=%b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, redirect_pc} !== {1'b1, 32'hC04}) begin
      errors++;
      $display("FAIL post_reset_accept: got v=%b rd=%h expected 1 c04", out_valid, redirect_pc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid    = 1'b0;
    branch      = 1'b0;
    func3       = 3'b000;
    rs1         = '0;
    rs2         = '0;
    pc          = '0;
    imm         = '0;
    pred_taken  = 1'b0;
    pred_target = '0;
    kill        = 1'b0;
    out_ready   = 1'b1;
    test_reset();
    test_pipe1();
    test_compare();
    test_mispredict_flush();
    test_wrap();
    test_backpressure();
    test_kill();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Pipelined branch-resolution stage for the RISC-V core.
- Accepts a branch op with operands, PC, immediate and front-end prediction over a valid/ready handshake.
- Resolves the condition and computes the target; flags mispredictions.
- Generates a redirect/flush, then squashes wrong-path ops for a programmable window.
- Generalises the combinational comparator to XLEN, 1 or 2 pipeline stages and a squash FSM.

Parameters:
XLEN, 32, operand/PC width
PIPE_STAGES, 1, 1 = result registered once; 2 = compare registered, then output registered
SQUASH_CYCLES, 2, cycles wrong-path inputs are dropped after a flush (>=1)
CNT_WIDTH, 32, width of performance counters

Ports:
clk  in  1  clock
rstN  in  1  asynchronous active-low reset
in_valid  in  1  op presented
in_ready  out  1  unit can accept
branch  in  1  op is a conditional branch; 0 = pass-through, never taken
func3  in  3  branch type (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU)
rs1, rs2  in  XLEN  operands
pc  in  XLEN  branch PC
imm  in  XLEN  sign-extended B-immediate
pred_taken  in  1  front-end prediction
pred_target  in  XLEN  predicted target
out_valid  out  1  result available
out_ready  in  1  consumer accepts
taken  out  1  resolved direction
target  out  XLEN  pc+imm, modulo 2^XLEN
mispredict  out  1  result mispredicted
redirect_pc  out  XLEN  taken ? target : pc+4
flush  out  1  one-cycle pulse on mispredict handshake
kill  in  1  external flush (trap); empties unit
illegal  out  1  branch=1 with func3 010/011

Behaviour:
- Reset: all outputs 0; pipeline empty; FSM in RUN.
- Compare rules:
  - BLT/BGE compare signed XLEN two's complement.
  - BLTU/BGEU compare raw bit patterns unsigned; no magnitude conversion.
  - func3 010/011 with branch=1: taken=0, illegal=1, mispredict computed normally.
- mispredict = (taken != pred_taken) | (taken & pred_target != target).
- Pipeline advance:
  - advance = !out_valid | out_ready.
  - in_ready = advance.
  - Accept on in_valid & in_ready.
  - Latency from accept to out_valid = PIPE_STAGES cycles with out_ready held high.
  - Throughput 1 op/cycle.
- Output hold: while out_valid & !out_ready, all outputs stable and the stage-1 register (PIPE_STAGES=2) holds.
- FSM states:
  - RUN to SQUASH: on out_valid & out_ready & mispredict, flush=1 for that cycle.
  - Entering SQUASH invalidates any younger op in stage 1 and clears the squash counter.
  - SQUASH: in_ready=1; accepted inputs are dropped and produce no output. Counter increments each cycle; returns to RUN after SQUASH_CYCLES cycles.
  - Another mispredict cannot occur in SQUASH because the pipeline is empty.
- kill:
  - Highest priority; synchronous.
  - Next cycle: pipeline empty, out_valid=0, FSM RUN, counter cleared.
  - Any input accepted in the kill cycle is dropped.
  - flush is not asserted if kill coincides with a mispredict handshake.
- Non-branch ops (branch=0): taken=0, redirect_pc=pc+4; mispredict if pred_taken=1.
- Wrap: pc+4 and pc+imm wrap modulo 2^XLEN.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- Defined:
  - Adds outputs br_count and mispred_count, CNT_WIDTH each.
  - They count branch=1 results handshaked and mispredicting results handshaked.
  - Saturate at all-ones; reset to 0.
  - Not cleared by kill.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Signed vs unsigned: BLT rs1=0xFFFFFFFF, rs2=1 -> taken=1; BLTU same operands -> taken=0; BGEU -> taken=1.
- Mispredict flush: BEQ rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 -> target=0x120, redirect_pc=0x120, mispredict=1, flush=1 for one cycle. Next SQUASH_CYCLES accepted ops produce no out_valid.
- Backpressure: 4 back-to-back ops, out_ready low cycles 2-4 -> outputs stable while stalled, in_ready=0, all 4 results in order, none lost.
- Wrap and not-taken: BNE rs1=rs2, pc=0xFFFFFFFC, pred_taken=1 -> taken=0, redirect_pc=0x0, mispredict=1.
- kill mid-operation (PIPE_STAGES=2): kill asserted with ops in both stages -> out_valid=0 next cycle, no flush, FSM RUN; next op resolves normally.
- Async reset: rstN low mid-SQUASH, off clock edge -> outputs 0 immediately; after release, unit accepts on the first cycle. Counters 0 with BRU_PERF_CNT_EN.
